// File: rtl/pingpong_fill_scheduler.sv
// rtl/pingpong_fill_scheduler.sv - ping-pong frame buffer fill scheduler
//
// Purpose: rotates images 1..NUM_IMAGES into two ping-pong frame buffers.
// Odd images go to buffer 0 and even images go to buffer 1. The block
// generates the write strobes one cycle behind the fill counter, which
// matches the reader's registered pixel output. Full buffers are handed to
// the display side.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   start_i, stop_i         begin rotation from idle / abort to idle
//   disp_done_i             display finished reading buffer disp_buf_o
//   image_number_o          image selected for the reader (0 = none)
//   buf0_empty_o/buf1_empty_o  buffer EMPTY or FILLING
//   wr_en_o, wr_buf_o, wr_addr_o  pipelined buffer write strobe
//   frame_valid_o, disp_buf_o     display-side handoff
//   frames_filled_o         completed fills, wraps at 2^16
//   busy_o                  scheduler not idle
module pingpong_fill_scheduler #(
  parameter int FRAME_PIXELS = 10000,
  parameter int NUM_IMAGES   = 4,
  parameter int ADDR_W       = 14
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              disp_done_i,
  output logic [2:0]        image_number_o,
  output logic              buf0_empty_o,
  output logic              buf1_empty_o,
  output logic              wr_en_o,
  output logic              wr_buf_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic              frame_valid_o,
  output logic              disp_buf_o,
  output logic [15:0]       frames_filled_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

  localparam logic [1:0] B_EMPTY   = 2'd0;
  localparam logic [1:0] B_FILLING = 2'd1;
  localparam logic [1:0] B_FULL    = 2'd2;

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(FRAME_PIXELS - 1);
  localparam logic [2:0]        LAST_IMG = 3'(NUM_IMAGES);

  state_e            state_q, state_d;
  logic [2:0]        next_img_q, next_img_d;
  logic [ADDR_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [1:0][1:0]   buf_q, buf_d;
  logic              disp_buf_q, disp_buf_d;
  logic [15:0]       frames_q, frames_d;
  logic              wr_en_q, wr_buf_q;
  logic [ADDR_W-1:0] wr_addr_q;

  logic       tgt;
  logic [2:0] adv_img;
  logic       adv_tgt;
  logic       frame_valid;

  // Odd images map to buffer 0, even images to buffer 1.
  assign tgt         = ~next_img_q[0];
  assign adv_img     = (next_img_q == LAST_IMG) ? 3'd1 : next_img_q + 3'd1;
  assign adv_tgt     = ~adv_img[0];
  assign frame_valid = (buf_q[disp_buf_q] == B_FULL);

  always_comb begin
    state_d    = state_q;
    next_img_d = next_img_q;
    fill_cnt_d = fill_cnt_q;
    buf_d      = buf_q;
    disp_buf_d = disp_buf_q;
    frames_d   = frames_q;

    // Display release is applied first so a FLUSH in the same cycle sees
    // the freed buffer when choosing between FILL and WAIT.
    if (disp_done_i && frame_valid) begin
      buf_d[disp_buf_q] = B_EMPTY;
      disp_buf_d        = ~disp_buf_q;
    end

    if (stop_i) begin
      state_d    = ST_IDLE;
      fill_cnt_d = '0;
      for (int b = 0; b < 2; b++) begin
        if (buf_q[b] == B_FILLING) buf_d[b] = B_EMPTY;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            if (buf_q[tgt] == B_EMPTY) begin
              state_d    = ST_FILL;
              buf_d[tgt] = B_FILLING;
            end else begin
              state_d = ST_WAIT;
            end
          end
        end
        ST_FILL: begin
          if (fill_cnt_q == LAST_PIX) begin
            state_d    = ST_FLUSH;
            fill_cnt_d = '0;
          end else begin
            fill_cnt_d = fill_cnt_q + ADDR_W'(1);
          end
        end
        ST_FLUSH: begin
          buf_d[tgt] = B_FULL;
          frames_d   = frames_q + 16'd1;
          next_img_d = adv_img;
          // With an odd rotation length the new target can be the buffer
          // just filled; buf_d already reflects that and any release.
          if (buf_d[adv_tgt] == B_EMPTY) begin
            state_d        = ST_FILL;
            buf_d[adv_tgt] = B_FILLING;
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (buf_q[tgt] == B_EMPTY) begin
            state_d    = ST_FILL;
            buf_d[tgt] = B_FILLING;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      next_img_q <= 3'd1;
      fill_cnt_q <= '0;
      buf_q      <= {B_EMPTY, B_EMPTY};
      disp_buf_q <= 1'b0;
      frames_q   <= 16'd0;
      wr_en_q    <= 1'b0;
      wr_buf_q   <= 1'b0;
      wr_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      next_img_q <= next_img_d;
      fill_cnt_q <= fill_cnt_d;
      buf_q      <= buf_d;
      disp_buf_q <= disp_buf_d;
      frames_q   <= frames_d;
      // Registered copy of the FILL indication; a write already in flight
      // still issues even when stop lands on the same edge.
      wr_en_q    <= (state_q == ST_FILL);
      wr_buf_q   <= tgt;
      wr_addr_q  <= fill_cnt_q;
    end
  end

  assign image_number_o  = (state_q == ST_FILL) ? next_img_q : 3'd0;
  assign buf0_empty_o    = (buf_q[0] != B_FULL);
  assign buf1_empty_o    = (buf_q[1] != B_FULL);
  assign wr_en_o         = wr_en_q;
  assign wr_buf_o        = wr_buf_q;
  assign wr_addr_o       = wr_addr_q;
  assign frame_valid_o   = frame_valid;
  assign disp_buf_o      = disp_buf_q;
  assign frames_filled_o = frames_q;
  assign busy_o          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pingpong_fill_scheduler.sv
// tb/tb_pingpong_fill_scheduler.sv - directed self-checking bench for pingpong_fill_scheduler
module tb_pingpong_fill_scheduler;

  localparam int FP = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, stop, disp_done;
  logic [2:0]    image_number;
  logic          buf0_empty, buf1_empty;
  logic          wr_en, wr_buf;
  logic [AW-1:0] wr_addr;
  logic          frame_valid, disp_buf;
  logic [15:0]   frames_filled;
  logic          busy;

  int errors = 0;
  int checks = 0;

  pingpong_fill_scheduler #(.FRAME_PIXELS(FP), .NUM_IMAGES(4), .ADDR_W(AW)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .start_i         (start),
    .stop_i          (stop),
    .disp_done_i     (disp_done),
    .image_number_o  (image_number),
    .buf0_empty_o    (buf0_empty),
    .buf1_empty_o    (buf1_empty),
    .wr_en_o         (wr_en),
    .wr_buf_o        (wr_buf),
    .wr_addr_o       (wr_addr),
    .frame_valid_o   (frame_valid),
    .disp_buf_o      (disp_buf),
    .frames_filled_o (frames_filled),
    .busy_o          (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".image_number"},  32'(image_number),  0);
    chk({tag, ".buf0_empty"},    32'(buf0_empty),    1);
    chk({tag, ".buf1_empty"},    32'(buf1_empty),    1);
    chk({tag, ".wr_en"},         32'(wr_en),         0);
    chk({tag, ".wr_buf"},        32'(wr_buf),        0);
    chk({tag, ".wr_addr"},       32'(wr_addr),       0);
    chk({tag, ".frame_valid"},   32'(frame_valid),   0);
    chk({tag, ".disp_buf"},      32'(disp_buf),      0);
    chk({tag, ".frames_filled"}, 32'(frames_filled), 0);
    chk({tag, ".busy"},          32'(busy),          0);
  endtask

  initial begin
    int seq[$];
    int toggles;
    logic [2:0] prev_img;
    logic prev_db;
    bit reached;

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; disp_done = 1'b0;
    step(); step();
    chk_reset("reset");
    rst_n = 1'b1;
    step();
    chk("idle.busy", 32'(busy), 0);

    // First fill: image 1 into buffer 0.
    start = 1'b1; step(); start = 1'b0;
    chk("f1.image", 32'(image_number), 1);
    chk("f1.wr_en_t1", 32'(wr_en), 0);
    chk("f1.buf0_empty", 32'(buf0_empty), 1);
    chk("f1.busy", 32'(busy), 1);
    for (int k = 0; k < FP; k++) begin
      step();
      chk("f1.wr_en", 32'(wr_en), 1);
      chk("f1.wr_addr", 32'(wr_addr), 32'(k));
      chk("f1.wr_buf", 32'(wr_buf), 0);
      chk("f1.image_pipe", 32'(image_number), (k < FP - 1) ? 1 : 0);
    end
    step();
    chk("f1.frame_valid", 32'(frame_valid), 1);
    chk("f1.frames", 32'(frames_filled), 1);
    chk("f1.wr_en_after", 32'(wr_en), 0);
    chk("f2.image", 32'(image_number), 2);
    chk("f1.buf0_empty", 32'(buf0_empty), 0);

    // Image 2 into buffer 1, then WAIT because buffer 0 is still full.
    step();
    chk("f2.wr_en", 32'(wr_en), 1);
    chk("f2.wr_buf", 32'(wr_buf), 1);
    chk("f2.wr_addr", 32'(wr_addr), 0);
    for (int k = 0; k < FP; k++) step();
    chk("wait.image", 32'(image_number), 0);
    chk("wait.buf0_empty", 32'(buf0_empty), 0);
    chk("wait.buf1_empty", 32'(buf1_empty), 0);
    chk("wait.frames", 32'(frames_filled), 2);
    chk("wait.busy", 32'(busy), 1);
    step(); step();
    chk("wait.hold", 32'(image_number), 0);

    // Release buffer 0; image 3 starts two edges later.
    disp_done = 1'b1; step(); disp_done = 1'b0;
    chk("dd.buf0_empty", 32'(buf0_empty), 1);
    chk("dd.disp_buf", 32'(disp_buf), 1);
    chk("dd.frame_valid", 32'(frame_valid), 1);
    chk("dd.image_edge1", 32'(image_number), 0);
    step();
    chk("dd.image_edge2", 32'(image_number), 3);

    // Abort image 3 at fill_cnt=3.
    step(); step(); step();
    chk("stop.pre_addr", 32'(wr_addr), 2);
    stop = 1'b1; step(); stop = 1'b0;
    chk("stop.busy", 32'(busy), 0);
    chk("stop.image", 32'(image_number), 0);
    chk("stop.buf0_empty", 32'(buf0_empty), 1);
    chk("stop.inflight_en", 32'(wr_en), 1);
    chk("stop.inflight_addr", 32'(wr_addr), 3);
    step();
    chk("stop.wr_en_off", 32'(wr_en), 0);
    chk("stop.frames", 32'(frames_filled), 2);
    chk("stop.disp_buf", 32'(disp_buf), 1);

    // start and stop together in IDLE stay in IDLE.
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    chk("ss.busy", 32'(busy), 0);
    chk("ss.image", 32'(image_number), 0);

    // Restart: image 3 refills from address 0.
    start = 1'b1; step(); start = 1'b0;
    chk("re.image", 32'(image_number), 3);
    step();
    chk("re.wr_en", 32'(wr_en), 1);
    chk("re.wr_addr", 32'(wr_addr), 0);
    chk("re.wr_buf", 32'(wr_buf), 0);
    for (int k = 0; k < FP; k++) step();
    chk("re.frames", 32'(frames_filled), 3);
    chk("re.wait_image", 32'(image_number), 0);

    // Drain every full buffer as soon as it is valid.
    toggles = 0;
    prev_img = image_number;
    prev_db = disp_buf;
    reached = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (disp_buf !== prev_db) toggles++;
      prev_db = disp_buf;
      if (frames_filled == 16'd5) begin
        reached = 1'b1;
        break;
      end
      if (image_number != 3'd0 && prev_img == 3'd0) seq.push_back(int'(image_number));
      prev_img = image_number;
      disp_done = frame_valid;
      step();
    end
    disp_done = 1'b0;
    chk("rot.reached", 32'(reached), 1);
    chk("rot.count", 32'(seq.size()), 2);
    chk("rot.first", (seq.size() > 0) ? 32'(seq[0]) : 32'hFFFF, 4);
    chk("rot.second", (seq.size() > 1) ? 32'(seq[1]) : 32'hFFFF, 1);
    chk("rot.frames", 32'(frames_filled), 5);
    chk("rot.toggles", 32'(toggles), 3);
    chk("rot.disp_buf", 32'(disp_buf), 0);
    chk("rot.next_image", 32'(image_number), 2);

    // Stop image 2, drain buffer 0, then disp_done with nothing valid.
    stop = 1'b1; step(); stop = 1'b0;
    disp_done = 1'b1; step(); disp_done = 1'b0;
    chk("nv.frame_valid", 32'(frame_valid), 0);
    chk("nv.disp_buf_pre", 32'(disp_buf), 1);
    disp_done = 1'b1; step(); disp_done = 1'b0;
    chk("nv.disp_buf", 32'(disp_buf), 1);
    chk("nv.buf0_empty", 32'(buf0_empty), 1);
    chk("nv.buf1_empty", 32'(buf1_empty), 1);
    chk("nv.frames", 32'(frames_filled), 5);

    // Reset during FILL forces reset values within the cycle.
    start = 1'b1; step(); start = 1'b0;
    chk("rf.image", 32'(image_number), 2);
    step(); step();
    rst_n = 1'b0;
    #1;
    chk_reset("midreset");
    step();
    rst_n = 1'b1;
    step();
    start = 1'b1; step(); start = 1'b0;
    chk("after_reset.image", 32'(image_number), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
